counter_ctrl: RTL and testbench
===============================

# counter_ctrl

Sequencing controller for the board's counter datapath: owns a WIDTH-bit up/down counter and runs it from a load value to a target value under Start/Stop/Pause commands. A programmable prescaler sets the step rate. Busy/Done/Tick outputs report progress. It sits between the switch/key inputs and the LED outputs in `top`. It replaces free-running enable-only counting with a commanded, terminating count.

## Interface
- `WIDTH`, 3: counter and value width in bits (≥1).
- `DIV`, 1: clocks per count step (≥1). 1 means one step per clock.

- `Clock`  in  1: single clock. All logic updates on the rising edge.
- `Resetn`  in  1: asynchronous, active-low reset.
- `Start`  in  1: begin a count run. Sampled in IDLE and DONE only.
- `Stop`  in  1: abort to IDLE. Highest priority.
- `Pause`  in  1: while high in RUN, freeze the counter and prescaler.
- `Up`  in  1: direction, 1 = increment, 0 = decrement. Latched at Start.
- `LoadVal`  in  WIDTH: start value. Latched at Start.
- `Target`  in  WIDTH: terminal value. Latched at Start.
- `Q`  out  WIDTH: current count.
- `Busy`  out  1: high in RUN and HOLD.
- `Done`  out  1: terminal indication. Its form is set by the configuration macro.
- `Tick`  out  1: one-cycle pulse on each count step.

## Operation
- States: IDLE, RUN, HOLD, DONE.
- Input priority per edge: Stop > Pause > Start.
- Stop, any state:
  - go to IDLE.
  - Q holds its value; prescaler clears to 0; Tick = 0.
- IDLE or DONE with Start = 1:
  - latch LoadVal, Target and Up.
  - Q ← LoadVal; prescaler ← 0.
  - if LoadVal == Target, go to DONE; otherwise go to RUN.
- RUN, Pause = 0:
  - prescaler counts 0..DIV-1.
  - when the prescaler reaches DIV-1: take a step (Q ← Q+1 if Up, else Q−1, modulo 2^WIDTH), pulse Tick, reset the prescaler to 0.
  - if the stepped value equals the latched Target, it is terminal (see Configuration).
- RUN, Pause = 1: go to HOLD. The prescaler and Q are frozen. HOLD with Pause = 0 returns to RUN with the prescaler resumed, not cleared.
- Start in RUN or HOLD is ignored.
- Input changes to LoadVal, Target or Up during a run have no effect.
- Wrap-around is silent. From 7, an increment gives 0; from 0, a decrement gives 7 (WIDTH = 3). A target behind the start value is reached via wrap.
- Reset values: state IDLE; Q = 0; Busy = 0; Done = 0; Tick = 0; prescaler and latched registers = 0.
- Resetn asserted mid-run forces the reset values immediately, without waiting for a clock edge.

## Timing
- Start sampled at edge k:
  - Q = LoadVal and Busy = 1 are visible after edge k.
  - the first step occurs at edge k + DIV.
- Terminal step at edge k + n·DIV, where n = (Target − LoadVal) mod 2^WIDTH if Up, else (LoadVal − Target) mod 2^WIDTH. Add any cycles spent in HOLD.
- Tick, Busy and Done are registered outputs and change only on edges, apart from reset.
- Pause asserted on the same edge a step would occur: the step is suppressed and the prescaler stays at DIV-1. The step fires on the first RUN edge after HOLD.
- Stop and terminal on the same edge: Stop wins; Done stays 0.
- Start in DONE: Done drops on that edge and the new run begins, with the same latency as from IDLE.

## Configuration
- `COUNT_CTRL_AUTORELOAD_EN`, undefined:
  - on the terminal step, go to DONE.
  - Busy = 0; Done is a level, held high until Stop or Start.
  - Q holds Target.
- `COUNT_CTRL_AUTORELOAD_EN`, defined:
  - on the terminal step, Done pulses high for one cycle, coincident with Tick.
  - on the next step boundary (DIV clocks later), Q ← latched LoadVal, with a Tick pulse; the state stays RUN.
  - the run repeats until Stop.
  - a Start with LoadVal == Target enters RUN and holds Q, pulsing Done every DIV clocks.

## Test plan
- WIDTH=3, DIV=1; LoadVal=2, Target=5, Up=1, Start pulse → Q = 2,3,4,5 on successive edges; 3 Tick pulses; Done=1 and Busy=0 from the 3rd edge after Start.
- LoadVal=1, Target=6, Up=0 → Q = 1,0,7,6 (wrap); Done after 3 steps.
- DIV=3; LoadVal=0, Target=2, Up=1; Pause for 4 cycles starting 1 cycle after the first Tick → second Tick arrives 3+4 clocks after the first; Q = 2 with Done.
- Stop on the same edge as the terminal step → IDLE; Done = 0; Q = 4 (LoadVal=2, Target=5); Busy = 0. A following Start restarts from LoadVal.
- Resetn low mid-run with Q=3 → Q=0, Busy=0, Done=0 asynchronously; Start is ignored until Resetn=1.
- `COUNT_CTRL_AUTORELOAD_EN` defined; LoadVal=6, Target=1, Up=1, DIV=1 → Q = 6,7,0,1,6,7,…; a 1-cycle Done pulse each time Q reaches 1; Busy stays 1 until Stop.

Source files
------------

// File: rtl/counter_ctrl_if.sv
// Command/status bundle for counter_ctrl.
// master: the controlling side (switches/keys) drives commands and reads status.
// slave:  the counter controller reads commands and drives status.
interface counter_ctrl_if #(
  parameter int WIDTH = 3
) ();

  logic             Start;
  logic             Stop;
  logic             Pause;
  logic             Up;
  logic [WIDTH-1:0] LoadVal;
  logic [WIDTH-1:0] Target;
  logic [WIDTH-1:0] Q;
  logic             Busy;
  logic             Done;
  logic             Tick;

  modport master (
    output Start, Stop, Pause, Up, LoadVal, Target,
    input  Q, Busy, Done, Tick
  );

  modport slave (
    input  Start, Stop, Pause, Up, LoadVal, Target,
    output Q, Busy, Done, Tick
  );

endinterface

// File: rtl/counter_ctrl.sv
// Commanded up/down counter: runs from a latched load value to a latched
// target under Start/Stop/Pause, stepping once every DIV clocks.
// Optional feature macro: COUNT_CTRL_AUTORELOAD_EN
//   undefined: terminal step enters DONE, Done is a level, Q holds Target.
//   defined:   terminal step pulses Done, the next step boundary reloads
//              LoadVal and the run repeats until Stop.
module counter_ctrl #(
  parameter int WIDTH = 3,
  parameter int DIV   = 1
) (
  input  logic           Clock,
  input  logic           Resetn,
  counter_ctrl_if.slave  bus
);

  localparam int            PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             up_q, up_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
`ifdef COUNT_CTRL_AUTORELOAD_EN
  // Set after a terminal step: the next step boundary reloads LoadVal.
  logic             pending_q, pending_d;
`endif

  logic [WIDTH-1:0] step_val_s;
  logic             at_step_s;

  // Value after one step in the latched direction; wraps modulo 2^WIDTH.
  assign step_val_s = up_q ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
  assign at_step_s  = (presc_q == PRESC_MAX);

  // Next-state, datapath and output decode; Stop overrides everything.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    presc_d  = presc_q;
    load_d   = load_q;
    target_d = target_q;
    up_d     = up_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
`ifdef COUNT_CTRL_AUTORELOAD_EN
    pending_d = pending_q;
`endif
    if (bus.Stop) begin
      state_d = ST_IDLE;
      presc_d = {PW{1'b0}};
`ifdef COUNT_CTRL_AUTORELOAD_EN
      pending_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.Start) begin
            load_d   = bus.LoadVal;
            target_d = bus.Target;
            up_d     = bus.Up;
            q_d      = bus.LoadVal;
            presc_d  = {PW{1'b0}};
`ifdef COUNT_CTRL_AUTORELOAD_EN
            pending_d = 1'b0;
            state_d   = ST_RUN;
`else
            if (bus.LoadVal == bus.Target) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
`endif
          end else begin
            // Done is a level while parked in DONE.
            done_d = (state_q == ST_DONE);
          end
        end
        ST_RUN, ST_HOLD: begin
          if (bus.Pause) begin
            // Freeze: prescaler and Q keep their values.
            state_d = ST_HOLD;
          end else begin
            // Leaving HOLD resumes counting on the same edge.
            state_d = ST_RUN;
            if (at_step_s) begin
              presc_d = {PW{1'b0}};
              tick_d  = 1'b1;
`ifdef COUNT_CTRL_AUTORELOAD_EN
              if (load_q == target_q) begin
                done_d = 1'b1;
              end else if (pending_q) begin
                q_d       = load_q;
                pending_d = 1'b0;
              end else begin
                q_d = step_val_s;
                if (step_val_s == target_q) begin
                  done_d    = 1'b1;
                  pending_d = 1'b1;
                end else begin
                  done_d = 1'b0;
                end
              end
`else
              q_d = step_val_s;
              if (step_val_s == target_q) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_RUN;
              end
`endif
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          presc_d = {PW{1'b0}};
        end
      endcase
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
  end

  // State and registered outputs; async reset clears everything at once.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= ST_IDLE;
      q_q      <= {WIDTH{1'b0}};
      presc_q  <= {PW{1'b0}};
      load_q   <= {WIDTH{1'b0}};
      target_q <= {WIDTH{1'b0}};
      up_q     <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef COUNT_CTRL_AUTORELOAD_EN
      pending_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      presc_q  <= presc_d;
      load_q   <= load_d;
      target_q <= target_d;
      up_q     <= up_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef COUNT_CTRL_AUTORELOAD_EN
      pending_q <= pending_d;
`endif
    end
  end

  assign bus.Q    = q_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.Tick = tick_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: one DIV=1 and one DIV=3 instance share
// the same command inputs. Observations are packed as {Q, Busy, Done, Tick}.
module tb_counter_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start, stop, pause, up;
  logic [2:0] load, target;
  int         checks;
  int         errors;

`ifdef COUNT_CTRL_AUTORELOAD_EN
  localparam logic BUSY_END = 1'b1;
`else
  localparam logic BUSY_END = 1'b0;
`endif

  counter_ctrl_if #(.WIDTH(3)) if1 ();
  counter_ctrl_if #(.WIDTH(3)) if3 ();

  assign if1.Start = start;   assign if3.Start = start;
  assign if1.Stop = stop;     assign if3.Stop = stop;
  assign if1.Pause = pause;   assign if3.Pause = pause;
  assign if1.Up = up;         assign if3.Up = up;
  assign if1.LoadVal = load;  assign if3.LoadVal = load;
  assign if1.Target = target; assign if3.Target = target;

  counter_ctrl #(.WIDTH(3), .DIV(1)) dut1 (.Clock(clk), .Resetn(rst_n), .bus(if1.slave));
  counter_ctrl #(.WIDTH(3), .DIV(3)) dut3 (.Clock(clk), .Resetn(rst_n), .bus(if3.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [5:0] obs1();
    return {if1.Q, if1.Busy, if1.Done, if1.Tick};
  endfunction

  function automatic logic [5:0] obs3();
    return {if3.Q, if3.Busy, if3.Done, if3.Tick};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b1;
    cyc();
    stop  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; pause = 1'b0; up = 1'b0;
    load = 3'd0; target = 3'd0;
    #3;
    checks++;
    if (obs1() !== 6'b000_000) begin
      errors++; $display("FAIL reset_div1: got %b expected %b", obs1(), 6'b000_000);
    end
    checks++;
    if (obs3() !== 6'b000_000) begin
      errors++; $display("FAIL reset_div3: got %b expected %b", obs3(), 6'b000_000);
    end
    #9 rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    logic [5:0] exp_v [5];
    exp_v = '{6'b010_100, 6'b011_101, 6'b100_101, 6'b101_011, 6'b101_010};
    clear();
    load = 3'd2; target = 3'd5; up = 1'b1; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      start = 1'b0;
      checks++;
      if (obs1() !== exp_v[i]) begin
        errors++; $display("FAIL count_up edge %0d: got %b expected %b", i, obs1(), exp_v[i]);
      end
    end
  endtask

  task automatic test_count_down_wrap();
    logic [5:0] exp_v [5];
    exp_v = '{6'b001_100, 6'b000_101, 6'b111_101, 6'b110_011, 6'b110_010};
    clear();
    load = 3'd1; target = 3'd6; up = 1'b0; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      start = 1'b0;
      checks++;
      if (obs1() !== exp_v[i]) begin
        errors++; $display("FAIL count_down edge %0d: got %b expected %b", i, obs1(), exp_v[i]);
      end
    end
  endtask

  task automatic test_equal_start();
    clear();
    load = 3'd3; target = 3'd3; up = 1'b1; start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      start = 1'b0;
      checks++;
      if (obs1() !== 6'b011_010) begin
        errors++; $display("FAIL equal_start edge %0d: got %b expected %b", i, obs1(), 6'b011_010);
      end
    end
  endtask

  task automatic test_start_in_done();
    logic [5:0] exp_v [6];
    exp_v = '{6'b011_100, 6'b100_011, 6'b100_010, 6'b110_100, 6'b111_101, 6'b000_011};
    clear();
    load = 3'd3; target = 3'd4; up = 1'b1; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      start = (i == 2);
      if (i == 2) begin
        load = 3'd6; target = 3'd0;
      end
      checks++;
      if (obs1() !== exp_v[i]) begin
        errors++; $display("FAIL start_in_done edge %0d: got %b expected %b", i, obs1(), exp_v[i]);
      end
    end
  endtask

  task automatic test_autoreload();
    logic [5:0] exp_v [9];
    exp_v = '{6'b110_100, 6'b111_101, 6'b000_101, 6'b001_111, 6'b110_101,
              6'b111_101, 6'b000_101, 6'b001_111, 6'b110_101};
    clear();
    load = 3'd6; target = 3'd1; up = 1'b1; start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      start = 1'b0;
      checks++;
      if (obs1() !== exp_v[i]) begin
        errors++; $display("FAIL autoreload edge %0d: got %b expected %b", i, obs1(), exp_v[i]);
      end
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++;
    if (obs1() !== 6'b110_000) begin
      errors++; $display("FAIL autoreload_stop: got %b expected %b", obs1(), 6'b110_000);
    end
  endtask

  task automatic test_start_ignored();
    clear();
    load = 3'd0; target = 3'd5; up = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    start = 1'b1; load = 3'd4; target = 3'd0; up = 1'b0;
    cyc();
    start = 1'b0;
    checks++;
    if (obs1() !== 6'b010_101) begin
      errors++; $display("FAIL start_ignored: got %b expected %b", obs1(), 6'b010_101);
    end
    cyc();
    checks++;
    if (obs1() !== 6'b011_101) begin
      errors++; $display("FAIL inputs_ignored: got %b expected %b", obs1(), 6'b011_101);
    end
  endtask

  task automatic test_stop_on_terminal();
    clear();
    load = 3'd2; target = 3'd5; up = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++;
    if (obs1() !== 6'b100_000) begin
      errors++; $display("FAIL stop_terminal: got %b expected %b", obs1(), 6'b100_000);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (obs1() !== 6'b010_100) begin
      errors++; $display("FAIL restart_after_stop: got %b expected %b", obs1(), 6'b010_100);
    end
  endtask

  task automatic test_pause();
    int gap;
    logic [5:0] exp_end;
    exp_end = {3'b010, BUSY_END, 1'b1, 1'b1};
    clear();
    load = 3'd0; target = 3'd2; up = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    cyc();
    checks++;
    if (obs3() !== 6'b001_101) begin
      errors++; $display("FAIL pause_first_tick: got %b expected %b", obs3(), 6'b001_101);
    end
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (obs3() !== 6'b001_100) begin
        errors++; $display("FAIL pause_hold %0d: got %b expected %b", i, obs3(), 6'b001_100);
      end
    end
    pause = 1'b0;
    gap = 4;
    for (int i = 0; i < 20; i++) begin
      cyc();
      gap++;
      if (if3.Tick === 1'b1) break;
    end
    checks++;
    if (gap !== 7) begin
      errors++; $display("FAIL pause_tick_gap: got %0d expected %0d", gap, 7);
    end
    checks++;
    if (obs3() !== exp_end) begin
      errors++; $display("FAIL pause_end: got %b expected %b", obs3(), exp_end);
    end
  endtask

  task automatic test_pause_on_step();
    clear();
    load = 3'd0; target = 3'd3; up = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    checks++;
    if (obs3() !== 6'b000_100) begin
      errors++; $display("FAIL pause_on_step_suppressed: got %b expected %b", obs3(), 6'b000_100);
    end
    cyc();
    checks++;
    if (obs3() !== 6'b001_101) begin
      errors++; $display("FAIL pause_on_step_resume: got %b expected %b", obs3(), 6'b001_101);
    end
  endtask

  task automatic test_reset_midrun();
    clear();
    load = 3'd0; target = 3'd7; up = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    cyc();
    checks++;
    if (obs1() !== 6'b011_101) begin
      errors++; $display("FAIL midrun_before_reset: got %b expected %b", obs1(), 6'b011_101);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obs1() !== 6'b000_000) begin
      errors++; $display("FAIL async_reset: got %b expected %b", obs1(), 6'b000_000);
    end
    load = 3'd5; start = 1'b1;
    cyc();
    checks++;
    if (obs1() !== 6'b000_000) begin
      errors++; $display("FAIL start_in_reset: got %b expected %b", obs1(), 6'b000_000);
    end
    start = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
`ifndef COUNT_CTRL_AUTORELOAD_EN
    test_count_up();
    test_count_down_wrap();
    test_equal_start();
    test_start_in_done();
`else
    test_autoreload();
`endif
    test_start_ignored();
    test_stop_on_terminal();
    test_pause();
    test_pause_on_step();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
